// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions used by the MEM-stage access engine and
// the writeback checker.
//   - SIZE_BYTE / SIZE_HALF / SIZE_WORD : mem_size encodings (2'b11 acts as word)
//   - mau_state_e                       : access FSM states IDLE / BUSY / DONE
//   - lane_wstrb / lane_wdata           : store byte-lane steering helpers
//   - is_misaligned                     : natural-alignment test for an access
package mips_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } mau_state_e;

  // Byte-lane enables for a store. Halfwords only look at off[1], so a
  // misaligned halfword is silently forced onto its aligned pair of lanes.
  function automatic logic [3:0] lane_wstrb(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] strb;
    case (size)
      SIZE_BYTE: strb = 4'b0001 << off;
      SIZE_HALF: strb = off[1] ? 4'b1100 : 4'b0011;
      default:   strb = 4'b1111;
    endcase
    return strb;
  endfunction

  // Store data replicated across every lane so the strobes alone pick the bytes.
  function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] sd);
    logic [31:0] data;
    case (size)
      SIZE_BYTE: data = {4{sd[7:0]}};
      SIZE_HALF: data = {2{sd[15:0]}};
      default:   data = sd;
    endcase
    return data;
  endfunction

  // Halfwords need off[0] clear; words (and the reserved size) need off clear.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    logic mis;
    case (size)
      SIZE_BYTE: mis = 1'b0;
      SIZE_HALF: mis = off[0];
      default:   mis = (off != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-memory bus between the MEM-stage access engine and data memory.
//   dmem_req   : request, held until ack        (master -> slave)
//   dmem_we    : 1 = write transaction          (master -> slave)
//   dmem_addr  : word-aligned byte address      (master -> slave)
//   dmem_wstrb : byte-lane write enables        (master -> slave)
//   dmem_wdata : lane-replicated store data     (master -> slave)
//   dmem_ack   : one-cycle completion pulse     (slave -> master)
//   dmem_rdata : read word, valid with dmem_ack (slave -> master)
interface mem_access_unit_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_wstrb;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wstrb, dmem_wdata,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wstrb, dmem_wdata,
    output dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/load_extract.sv
// Combinational load-lane select plus sign/zero extension.
//   rdata       : 32-bit word read from memory
//   size        : access size (byte / half / word; 2'b11 acts as word)
//   off         : byte offset addr[1:0]; halfwords use off[1] only
//   is_unsigned : 1 = zero-extend, 0 = sign-extend
//   data        : extended 32-bit load result
module load_extract
  import mips_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  size,
  input  logic [1:0]  off,
  input  logic        is_unsigned,
  output logic [31:0] data
);

  logic [7:0]  lane_b_s;
  logic [15:0] lane_h_s;

  // Pick the addressed lane and extend it to a full word.
  always_comb begin
    lane_b_s = 8'h00;
    lane_h_s = 16'h0000;
    data     = rdata;
    case (size)
      SIZE_BYTE: begin
        case (off)
          2'd0:    lane_b_s = rdata[7:0];
          2'd1:    lane_b_s = rdata[15:8];
          2'd2:    lane_b_s = rdata[23:16];
          default: lane_b_s = rdata[31:24];
        endcase
        if (is_unsigned) begin
          data = {24'h00_0000, lane_b_s};
        end else begin
          data = {{24{lane_b_s[7]}}, lane_b_s};
        end
      end
      SIZE_HALF: begin
        lane_h_s = off[1] ? rdata[31:16] : rdata[15:0];
        if (is_unsigned) begin
          data = {16'h0000, lane_h_s};
        end else begin
          data = {{16{lane_h_s[15]}}, lane_h_s};
        end
      end
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access engine for the 5-stage MIPS pipeline.
// Issues one req/ack bus transaction per load/store, stalls the pipeline
// while it is in flight, and returns extracted load data to MEM/WB.
//   clk, reset        : clock, asynchronous active-high reset
//   mem_read_in/write : load / store request from EX/MEM (write wins if both)
//   mem_size_in       : 00 byte, 01 half, 10 word, 11 treated as word
//   mem_unsigned_in   : 1 = zero-extend loads
//   addr_in           : byte address from the ALU
//   store_data_in     : store data (rt)
//   dmem              : data-memory bus (master side)
//   read_data_out     : extracted load data, held until the next load completes
//   mem_stall         : freeze the front of the pipeline while high
//   bus_err           : one-cycle pulse when the ack wait times out
//   misalign          : only with MEM_MISALIGN_TRAP_EN defined; flags a
//                       misaligned access, which is then skipped on the bus
// Parameters: MAX_WAIT (BUSY cycles before timeout, 1..255), RESET_RDATA.
module mem_access_unit
  import mips_pkg::*;
#(
  parameter int unsigned MAX_WAIT    = 255,
  parameter logic [31:0] RESET_RDATA = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               mem_read_in,
  input  logic               mem_write_in,
  input  logic [1:0]         mem_size_in,
  input  logic               mem_unsigned_in,
  input  logic [31:0]        addr_in,
  input  logic [31:0]        store_data_in,
  mem_access_unit_if.master  dmem,
  output logic [31:0]        read_data_out,
  output logic               mem_stall,
  output logic               bus_err
`ifdef MEM_MISALIGN_TRAP_EN
  ,
  output logic               misalign
`endif
);

  // Counter value in the last BUSY cycle that may still accept an ack.
  localparam logic [7:0] LAST_CNT = 8'(MAX_WAIT - 1);

  mau_state_e  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        bus_err_q, bus_err_d;
  logic [1:0]  size_q, size_d;
  logic [1:0]  off_q, off_d;
  logic        uns_q, uns_d;

  logic        access_s;
  logic        misalign_hit_s;
  logic        issue_s;
  logic        mem_stall_s;
  logic [31:0] ext_s;

  assign access_s = mem_read_in | mem_write_in;

`ifdef MEM_MISALIGN_TRAP_EN
  assign misalign_hit_s = access_s && (state_q == IDLE) && is_misaligned(mem_size_in, addr_in[1:0]);
  assign misalign       = misalign_hit_s & ~reset;
`else
  assign misalign_hit_s = 1'b0;
`endif

  assign issue_s = access_s & ~misalign_hit_s;

  // Size/offset/sign are latched at issue so extraction does not depend on
  // EX/MEM staying frozen.
  load_extract u_load_extract (
    .rdata       (dmem.dmem_rdata),
    .size        (size_q),
    .off         (off_q),
    .is_unsigned (uns_q),
    .data        (ext_s)
  );

  // Next-state and output decode for the IDLE/BUSY/DONE access FSM.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_d       = req_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wstrb_d     = wstrb_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    bus_err_d   = 1'b0;
    size_d      = size_q;
    off_d       = off_q;
    uns_d       = uns_q;
    mem_stall_s = 1'b0;
    case (state_q)
      IDLE: begin
        mem_stall_s = access_s;
        cnt_d       = 8'd0;
        if (issue_s) begin
          state_d = BUSY;
          req_d   = 1'b1;
          we_d    = mem_write_in;
          addr_d  = {addr_in[31:2], 2'b00};
          wstrb_d = mem_write_in ? lane_wstrb(mem_size_in, addr_in[1:0]) : 4'b0000;
          wdata_d = lane_wdata(mem_size_in, store_data_in);
          size_d  = mem_size_in;
          off_d   = addr_in[1:0];
          uns_d   = mem_unsigned_in;
        end else if (access_s) begin
          // Trapped misaligned access: no bus cycle, just the DONE release.
          state_d = DONE;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        mem_stall_s = 1'b1;
        if (dmem.dmem_ack) begin
          state_d = DONE;
          req_d   = 1'b0;
          we_d    = 1'b0;
          wstrb_d = 4'b0000;
          if (!we_q) begin
            rdata_d = ext_s;
          end else begin
            rdata_d = rdata_q;
          end
        end else if (cnt_q == LAST_CNT) begin
          state_d   = DONE;
          req_d     = 1'b0;
          we_d      = 1'b0;
          wstrb_d   = 4'b0000;
          bus_err_d = 1'b1;
          rdata_d   = 32'h0000_0000;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DONE: begin
        // Stall drops for this one cycle so the instruction retires once.
        state_d = IDLE;
        cnt_d   = 8'd0;
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
        we_d    = 1'b0;
        wstrb_d = 4'b0000;
        cnt_d   = 8'd0;
      end
    endcase
  end

  // State and bus-output registers; reset drops the request immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= 8'd0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= 32'h0000_0000;
      wstrb_q   <= 4'b0000;
      wdata_q   <= 32'h0000_0000;
      rdata_q   <= RESET_RDATA;
      bus_err_q <= 1'b0;
      size_q    <= SIZE_WORD;
      off_q     <= 2'b00;
      uns_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      req_q     <= req_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wstrb_q   <= wstrb_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      bus_err_q <= bus_err_d;
      size_q    <= size_d;
      off_q     <= off_d;
      uns_q     <= uns_d;
    end
  end

  assign dmem.dmem_req   = req_q;
  assign dmem.dmem_we    = we_q;
  assign dmem.dmem_addr  = addr_q;
  assign dmem.dmem_wstrb = wstrb_q;
  assign dmem.dmem_wdata = wdata_q;
  assign read_data_out   = rdata_q;
  assign bus_err         = bus_err_q;
  // Stall is released while reset is held so the pipeline is never frozen by it.
  assign mem_stall       = mem_stall_s & ~reset;

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized self-checking bench for mem_access_unit, with a small memory
// responder and a transaction-level model of the expected per-cycle outputs.
module tb_mem_access_unit;
  import mips_pkg::*;

  localparam int unsigned MAXW   = 4;
  localparam logic [31:0] RST_RD = 32'hA5A5_5A5A;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_read_in, mem_write_in, mem_unsigned_in;
  logic [1:0]  mem_size_in;
  logic [31:0] addr_in, store_data_in;
  logic [31:0] read_data_out;
  logic        mem_stall, bus_err;
`ifdef MEM_MISALIGN_TRAP_EN
  logic        misalign;
`endif

  mem_access_unit_if bus();

  mem_access_unit #(.MAX_WAIT(MAXW), .RESET_RDATA(RST_RD)) dut (
    .clk             (clk),
    .reset           (reset),
    .mem_read_in     (mem_read_in),
    .mem_write_in    (mem_write_in),
    .mem_size_in     (mem_size_in),
    .mem_unsigned_in (mem_unsigned_in),
    .addr_in         (addr_in),
    .store_data_in   (store_data_in),
    .dmem            (bus),
    .read_data_out   (read_data_out),
    .mem_stall       (mem_stall),
    .bus_err         (bus_err)
`ifdef MEM_MISALIGN_TRAP_EN
    ,
    .misalign        (misalign)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int stall_cnt = 0;
  logic        check_en = 1'b0;
  logic        e_stall, e_req, e_we, e_err;
  logic [31:0] e_addr, e_wdata, e_rdo;
  logic [3:0]  e_wstrb;
  logic [31:0] rdo_m;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: extracted load value from plain shifts and modular arithmetic.
  function automatic logic [31:0] m_load(input logic [31:0] w, input logic [1:0] sz,
                                         input logic [31:0] a, input logic u);
    int unsigned v;
    if (sz == 2'd0) begin
      v = (w >> (8 * (a % 4))) % 256;
      if (!u && v >= 128) v = v + 32'hFFFF_FF00;
    end else if (sz == 2'd1) begin
      v = (w >> (8 * (a & 2))) % 65536;
      if (!u && v >= 32768) v = v + 32'hFFFF_0000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  function automatic logic [3:0] m_wstrb(input logic [1:0] sz, input logic [31:0] a);
    int unsigned s;
    if (sz == 2'd0)      s = 1 << (a % 4);
    else if (sz == 2'd1) s = 3 << (a & 2);
    else                 s = 15;
    return 4'(s);
  endfunction

  function automatic logic [31:0] m_wdata(input logic [1:0] sz, input logic [31:0] sd);
    if (sz == 2'd0)      return (sd % 256) * 32'h0101_0101;
    else if (sz == 2'd1) return (sd % 65536) * 32'h0001_0001;
    else                 return sd;
  endfunction

  function automatic logic m_misaligned(input logic [1:0] sz, input logic [31:0] a);
    if (sz == 2'd1) return (a % 2) != 0;
    if (sz >= 2'd2) return (a % 4) != 0;
    return 1'b0;
  endfunction

  // Single per-cycle comparison of DUT outputs against the model's expectations.
  always @(negedge clk) begin
    if (check_en) begin
      check("mem_stall", {31'd0, mem_stall}, {31'd0, e_stall});
      check("dmem_req", {31'd0, bus.dmem_req}, {31'd0, e_req});
      if (e_req) begin
        check("dmem_we", {31'd0, bus.dmem_we}, {31'd0, e_we});
        check("dmem_addr", bus.dmem_addr, e_addr);
        if (e_we) begin
          check("dmem_wstrb", {28'd0, bus.dmem_wstrb}, {28'd0, e_wstrb});
          check("dmem_wdata", bus.dmem_wdata, e_wdata);
        end
      end
      check("bus_err", {31'd0, bus_err}, {31'd0, e_err});
      check("read_data_out", read_data_out, e_rdo);
      if (mem_stall) stall_cnt++;
    end
  end

  // One instruction through MEM: d = BUSY cycle (1-based) carrying the ack;
  // d > MAXW means the memory never answers.
  task automatic run_instr(input logic rd, input logic wr, input logic [1:0] sz, input logic u,
                           input logic [31:0] a, input logic [31:0] sd, input int d,
                           input logic [31:0] w);
    logic acc, tmo;
    int   b;
    acc = rd | wr;
    @(posedge clk); #1;
    mem_read_in = rd; mem_write_in = wr; mem_size_in = sz; mem_unsigned_in = u;
    addr_in = a; store_data_in = sd;
    bus.dmem_ack = 1'($urandom_range(0, 1));
    bus.dmem_rdata = $urandom;
    stall_cnt = 0;
    e_stall = acc; e_req = 1'b0; e_err = 1'b0; e_rdo = rdo_m;
    if (!acc) return;
`ifdef MEM_MISALIGN_TRAP_EN
    if (m_misaligned(sz, a)) begin
      @(posedge clk); #1;
      bus.dmem_ack = 1'b0;
      e_stall = 1'b0; e_req = 1'b0; e_err = 1'b0;
      return;
    end
`endif
    tmo = (d > int'(MAXW));
    b   = tmo ? int'(MAXW) : d;
    for (int k = 1; k <= b; k++) begin
      @(posedge clk); #1;
      bus.dmem_ack   = (!tmo && k == d);
      bus.dmem_rdata = (!tmo && k == d) ? w : $urandom;
      e_stall = 1'b1; e_req = 1'b1; e_we = wr;
      e_addr  = a - (a % 4);
      e_wstrb = m_wstrb(sz, a);
      e_wdata = m_wdata(sz, sd);
    end
    @(posedge clk); #1;
    bus.dmem_ack   = 1'($urandom_range(0, 1));
    bus.dmem_rdata = $urandom;
    if (tmo)      rdo_m = 32'h0000_0000;
    else if (!wr) rdo_m = m_load(w, sz, a, u);
    e_stall = 1'b0; e_req = 1'b0; e_err = tmo; e_rdo = rdo_m;
  endtask

  initial begin
    logic [1:0]  sz;
    logic [31:0] a;
    reset = 1'b1;
    mem_read_in = 1'b0; mem_write_in = 1'b0; mem_size_in = 2'd0; mem_unsigned_in = 1'b0;
    addr_in = 32'd0; store_data_in = 32'd0;
    bus.dmem_ack = 1'b0; bus.dmem_rdata = 32'd0;

    // Model pins: hand-computed values from the test plan.
    check("pin_lb",  m_load(32'h80FF_7F01, 2'd0, 32'h103, 1'b0), 32'hFFFF_FF80);
    check("pin_lbu", m_load(32'h80FF_7F01, 2'd0, 32'h103, 1'b1), 32'h0000_0080);
    check("pin_lh",  m_load(32'h8001_FFFF, 2'd1, 32'h202, 1'b0), 32'hFFFF_8001);
    check("pin_sb_strb", {28'd0, m_wstrb(2'd0, 32'h301)}, 32'h0000_0002);
    check("pin_sb_data", m_wdata(2'd0, 32'h0000_00AB), 32'hABAB_ABAB);
    check("pin_sh_strb", {28'd0, m_wstrb(2'd1, 32'h302)}, 32'h0000_000C);
    check("pin_sh_data", m_wdata(2'd1, 32'h0000_BEEF), 32'hBEEF_BEEF);

    // Reset state.
    @(posedge clk); @(posedge clk); #1;
    check("rst_req",   {31'd0, bus.dmem_req}, 32'd0);
    check("rst_we",    {31'd0, bus.dmem_we}, 32'd0);
    check("rst_wstrb", {28'd0, bus.dmem_wstrb}, 32'd0);
    check("rst_addr",  bus.dmem_addr, 32'd0);
    check("rst_wdata", bus.dmem_wdata, 32'd0);
    check("rst_err",   {31'd0, bus_err}, 32'd0);
    check("rst_rdo",   read_data_out, RST_RD);
    reset = 1'b0;
    rdo_m = RST_RD;
    e_stall = 1'b0; e_req = 1'b0; e_we = 1'b0; e_err = 1'b0; e_rdo = RST_RD;
    e_addr = 32'd0; e_wdata = 32'd0; e_wstrb = 4'd0;
    check_en = 1'b1;

    // Directed test plan.
    run_instr(1'b1, 1'b0, 2'd2, 1'b0, 32'h100, 32'd0, 3, 32'hDEAD_BEEF);
    check("lw_rdo", read_data_out, 32'hDEAD_BEEF);
    check("lw_stall_cycles", stall_cnt, 32'd4);
    run_instr(1'b1, 1'b0, 2'd0, 1'b0, 32'h103, 32'd0, 1, 32'h80FF_7F01);
    check("lb_rdo", read_data_out, 32'hFFFF_FF80);
    check("min_stall_cycles", stall_cnt, 32'd2);
    run_instr(1'b1, 1'b0, 2'd0, 1'b1, 32'h103, 32'd0, 2, 32'h80FF_7F01);
    check("lbu_rdo", read_data_out, 32'h0000_0080);
    run_instr(1'b1, 1'b0, 2'd1, 1'b0, 32'h202, 32'd0, 1, 32'h8001_FFFF);
    check("lh_rdo", read_data_out, 32'hFFFF_8001);
    run_instr(1'b0, 1'b1, 2'd0, 1'b0, 32'h301, 32'h0000_00AB, 2, 32'h1234_5678);
    check("sb_keeps_rdo", read_data_out, 32'hFFFF_8001);
    run_instr(1'b0, 1'b1, 2'd1, 1'b0, 32'h302, 32'h0000_BEEF, 1, 32'h0);
    run_instr(1'b1, 1'b1, 2'd2, 1'b0, 32'h404, 32'h0BAD_F00D, 1, 32'h7777_7777);
    check("rw_write_wins_rdo", read_data_out, 32'hFFFF_8001);
    run_instr(1'b1, 1'b0, 2'd2, 1'b0, 32'h500, 32'd0, 9, 32'h0);
    check("timeout_err", {31'd0, bus_err}, 32'd1);
    check("timeout_rdo", read_data_out, 32'd0);
    run_instr(1'b0, 1'b0, 2'd2, 1'b0, 32'h600, 32'd0, 1, 32'h0);

    // Randomized instruction stream.
    for (int i = 0; i < 300; i++) begin
      sz = 2'($urandom_range(0, 3));
      a  = $urandom;
      run_instr(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), sz,
                1'($urandom_range(0, 1)), a, $urandom,
                int'($urandom_range(1, MAXW + 2)), $urandom);
    end

    // Reset in the middle of a BUSY transaction.
    @(posedge clk); #1;
    check_en = 1'b0;
    mem_read_in = 1'b1; mem_write_in = 1'b0; mem_size_in = 2'd2; addr_in = 32'h700;
    bus.dmem_ack = 1'b0;
    @(posedge clk); #1;
    check("pre_rst_req", {31'd0, bus.dmem_req}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check("midrst_req",   {31'd0, bus.dmem_req}, 32'd0);
    check("midrst_stall", {31'd0, mem_stall}, 32'd0);
    check("midrst_rdo",   read_data_out, RST_RD);
    @(posedge clk); #1;
    reset = 1'b0; mem_read_in = 1'b0;
    @(posedge clk); #1;
    bus.dmem_ack = 1'b1; bus.dmem_rdata = 32'h1111_1111;
    @(posedge clk); #1;
    bus.dmem_ack = 1'b0;
    check("late_ack_req",   {31'd0, bus.dmem_req}, 32'd0);
    check("late_ack_stall", {31'd0, mem_stall}, 32'd0);
    check("late_ack_rdo",   read_data_out, RST_RD);

`ifdef MEM_MISALIGN_TRAP_EN
    // Trapped misaligned word load.
    @(posedge clk); #1;
    mem_read_in = 1'b1; mem_size_in = 2'd2; addr_in = 32'h102;
    #1;
    check("mis_flag",  {31'd0, misalign}, 32'd1);
    check("mis_stall", {31'd0, mem_stall}, 32'd1);
    @(posedge clk); #1;
    check("mis_no_req", {31'd0, bus.dmem_req}, 32'd0);
    check("mis_release", {31'd0, mem_stall}, 32'd0);
    check("mis_flag_off", {31'd0, misalign}, 32'd0);
    check("mis_rdo", read_data_out, RST_RD);
    mem_read_in = 1'b0;
`endif

    @(posedge clk); #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
MEM-stage data-memory access engine for the 5-stage MIPS pipeline. It sits between the EX/MEM register and the MEM/WB register.
- Takes the load/store controls, the ALU address and the store data from EX/MEM.
- Runs a req/ack transaction on the data-memory bus and stalls the pipeline while the transaction is in flight.
- Delivers size-extracted, sign/zero-extended load data to the MEM/WB read_data_in input.

Parameters:
MAX_WAIT, 255, cycles to wait for dmem_ack before aborting with bus_err (8-bit counter).
RESET_RDATA, 32'h0000_0000, reset value of read_data_out.

Ports:
clk  in  1  clock
reset  in  1  async active-high reset
mem_read_in  in  1  load request from EX/MEM
mem_write_in  in  1  store request from EX/MEM
mem_size_in  in  2  access size: 00 byte, 01 half, 10 word, 11 reserved (treated as word)
mem_unsigned_in  in  1  1 = zero-extend loads (lbu/lhu), 0 = sign-extend
addr_in  in  32  byte address (ALU result)
store_data_in  in  32  store data (rt value)
dmem_req  out  1  bus request, held until ack
dmem_we  out  1  1 = write transaction
dmem_addr  out  32  word-aligned address, {addr_in[31:2],2'b00}
dmem_wstrb  out  4  byte-lane write enables
dmem_wdata  out  32  lane-replicated store data
dmem_ack  in  1  one-cycle completion pulse from memory
dmem_rdata  in  32  read word, valid with dmem_ack
read_data_out  out  32  extracted load data to MEM/WB read_data_in
mem_stall  out  1  freeze PC, IF/ID, ID/EX and EX/MEM while high
bus_err  out  1  one-cycle pulse on ack timeout

Behaviour:
- Reset (asynchronous, active-high, clock clk):
  - state = IDLE; dmem_req, dmem_we, dmem_wstrb, bus_err = 0; dmem_addr, dmem_wdata = 0.
  - read_data_out = RESET_RDATA; wait counter = 0.
- FSM has three states: IDLE, BUSY, DONE.
- IDLE:
  - access = mem_read_in | mem_write_in. mem_stall = access, combinational.
  - On access, the next state is BUSY. Register dmem_req = 1, dmem_we = mem_write_in, dmem_addr, dmem_wstrb and dmem_wdata.
  - When mem_read_in and mem_write_in are both high, the write wins.
- BUSY:
  - mem_stall = 1. Outputs are held stable; the counter increments each cycle.
  - On dmem_ack: drop dmem_req. For a read, capture the extracted dmem_rdata into read_data_out. Next state is DONE.
  - If the counter reaches MAX_WAIT without an ack: drop dmem_req, pulse bus_err, set read_data_out = 0, next state is DONE.
- DONE:
  - mem_stall = 0 for exactly one cycle, so the pipeline advances and the instruction is not re-issued.
  - Next state is IDLE; the counter clears.
- Latency: minimum 2 stall cycles when ack arrives in the first BUSY cycle; stall cycles = ack wait + 1.
- Non-memory instructions (both inputs low) pass with no stall and no bus activity.
- read_data_out holds its value until the next load completes. Stores do not modify it.
- Store lanes, by addr_in[1:0]:
  - byte: wstrb = 0001 << off; wdata = {4{sd[7:0]}}.
  - half: wstrb = 0011 << off[1]*2; wdata = {2{sd[15:0]}}.
  - word: wstrb = 1111; wdata = sd.
- Load extraction:
  - byte lane = rdata[8*off +: 8]; half lane = rdata[16*off[1] +: 16].
  - Extend to 32 bits by mem_unsigned_in.
- dmem_ack seen in IDLE or DONE is ignored.
- Reset mid-transaction returns the block to IDLE immediately and drops dmem_req asynchronously. The bus must tolerate an abandoned request.

Optional Feature:
MEM_MISALIGN_TRAP_EN
- Defined:
  - Adds output port misalign (1 bit). It is combinational in IDLE, high for half with off[0] = 1 or word with off != 00.
  - A misaligned access issues no bus request. The FSM goes IDLE to DONE directly, with one stall cycle.
  - read_data_out is unchanged; misalign pulses for that cycle.
- Undefined:
  - No port. Misaligned low bits are silently forced aligned: half uses off[1] only, word ignores off.

Decomposition:
- Shared package mips_pkg holds:
  - SIZE_BYTE/SIZE_HALF/SIZE_WORD constants.
  - The state enum IDLE/BUSY/DONE.
- One sub-module is natural: load_extract, a combinational lane select plus sign/zero extend. It is reused by the later writeback checker.

Test Plan:
- lw: addr 0x100, ack after 3 cycles, rdata 0xDEADBEEF -> dmem_addr 0x100, mem_stall high 4 cycles, read_data_out = 0xDEADBEEF.
- lb/lbu: addr 0x103, rdata 0x80FF7F01 -> lb gives 0xFFFFFF80; lbu gives 0x00000080.
- lh: addr 0x202, rdata 0x8001FFFF -> 0xFFFF8001.
- sb: addr 0x301, sd 0x000000AB -> wstrb 0010, wdata 0xABABABAB, dmem_we 1.
- sh: addr 0x302, sd 0x0000BEEF -> wstrb 1100, wdata 0xBEEFBEEF.
- Timeout: no ack, MAX_WAIT = 4 -> bus_err pulses once, read_data_out 0, stall released.
- Reset: assert in BUSY -> dmem_req 0 and mem_stall 0 immediately; a later ack is ignored.
- With MEM_MISALIGN_TRAP_EN: lw at 0x102 -> misalign 1, no dmem_req, one stall cycle.
